// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Default widths match the register file (32-bit data, 5-bit address).
// md_entry_t is one queued mul/div result.
package wb_pkg;

  localparam int N_DEF = 32;
  localparam int R_DEF = 5;

  // One queued mul/div result; widths follow the default regfile geometry.
  typedef struct packed {
    logic [R_DEF-1:0] rd;
    logic [N_DEF-1:0] wd;
  } md_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with head-of-queue visibility.
// Latency: a push is visible at head on the cycle after the push edge.
// Backpressure: full is purely occupancy-based; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are only observed while non-empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: pipeline writeback wins, mul/div results queue and drain into idle slots.
// Latency: pipeline write is combinational same-cycle; mul/div result writes at least 1 cycle after accept.
// Backpressure: md_ready = !full from registered occupancy; continuous pipeline writes starve the queue.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int R     = R_DEF,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [R-1:0]      pipe_wa,
  input  logic [N-1:0]      pipe_wd,
  input  logic              md_issue,
  input  logic [R-1:0]      md_issue_rd,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [R-1:0]      md_rd,
  input  logic [N-1:0]      md_wd,
  output logic              we3,
  output logic [R-1:0]      wa3,
  output logic [N-1:0]      wd3,
  output logic [(2**R)-1:0] busy_mask,
  output logic              waw_err
);

  // The queued entry type is fixed to the package geometry; N and R must stay at their defaults.
  md_entry_t w_push_entry;
  md_entry_t w_head;

  logic w_full;
  logic w_empty;
  logic w_pipe_slot;
  logic w_drain;
  logic w_accept;
  logic w_push;
  logic w_waw_hit;

  logic [(2**R)-1:0] r_busy;
  logic [(2**R)-1:0] w_busy_nxt;
  logic              r_waw_err;

  assign w_pipe_slot  = pipe_we && (pipe_wa != '0);
  assign w_drain      = !w_pipe_slot && !w_empty;
  assign w_accept     = md_valid && md_ready;
  assign w_push       = w_accept && (md_rd != '0);
  assign w_push_entry = '{rd: md_rd, wd: md_wd};

  assign md_ready  = !w_full;
  assign busy_mask = r_busy;
  assign waw_err   = r_waw_err;

  sync_fifo #(
    .W     ($bits(md_entry_t)),
    .DEPTH (DEPTH)
  ) u_md_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_dat (w_push_entry),
    .pop      (w_drain),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  // Write-port mux: pipeline first, then the queue head; held quiet while in reset.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (w_pipe_slot) begin
      we3 = rst_n;
      wa3 = pipe_wa;
      wd3 = pipe_wd;
    end else if (!w_empty) begin
      we3 = rst_n;
      wa3 = w_head.rd;
      wd3 = w_head.wd;
    end
  end

  // Scoreboard next state: clear on drain first so a same-cycle issue to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_drain) w_busy_nxt[w_head.rd] = 1'b0;
    if (md_issue && (md_issue_rd != '0)) w_busy_nxt[md_issue_rd] = 1'b1;
  end

  // Write-after-write protocol violations, judged against the scoreboard as it stands this cycle.
  always_comb begin
    w_waw_hit = 1'b0;
    if (w_pipe_slot && r_busy[pipe_wa]) w_waw_hit = 1'b1;
    if (md_issue && (md_issue_rd != '0) && r_busy[md_issue_rd]) w_waw_hit = 1'b1;
    if (w_push && !r_busy[md_rd]) w_waw_hit = 1'b1;
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_waw_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_waw_hit) r_waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written corner sequences,
// and a randomized phase checked against a queue-based reference model.
// Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_wd;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] busy_mask;
  logic        waw_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_we     (pipe_we),
    .pipe_wa     (pipe_wa),
    .pipe_wd     (pipe_wd),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_rd       (md_rd),
    .md_wd       (md_wd),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .busy_mask   (busy_mask),
    .waw_err     (waw_err)
  );

  typedef struct {
    logic        pwe;
    logic [4:0]  pwa;
    logic [31:0] pwd;
    logic        iss;
    logic [4:0]  ird;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mwd;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  vec_t tbl[22];

  // reference model state
  ent_t q[$];
  bit   mbusy[32];
  bit   merr;
  logic [4:0] pend[$];

  function automatic vec_t mk(logic pwe, logic [4:0] pwa, logic [31:0] pwd,
                              logic iss, logic [4:0] ird,
                              logic mv, logic [4:0] mrd, logic [31:0] mwd,
                              logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
                              logic e_rdy, logic [31:0] e_busy, logic e_err);
    vec_t v;
    v.pwe = pwe; v.pwa = pwa; v.pwd = pwd;
    v.iss = iss; v.ird = ird;
    v.mv = mv; v.mrd = mrd; v.mwd = mwd;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                       input logic iss, input logic [4:0] ird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mwd);
    pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
    md_issue = iss; md_issue_rd = ird;
    md_valid = mv; md_rd = mrd; md_wd = mwd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    pend.delete();
    for (int j = 0; j < 32; j++) mbusy[j] = 1'b0;
    merr = 1'b0;
  endtask

  // Reset held across one rising edge; ends 1ns after the following edge.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic        slot, acc, drain, from_pend;
    logic        x_we, x_rdy;
    logic [4:0]  x_wa, r_pick, hrd;
    logic [31:0] x_wd, x_busy;

    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cols: pipe_we wa wd | issue rd | md_valid rd wd || we3 wa3 wd3 rdy busy err
    tbl[0]  = mk(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0,            1, 32'h0,   0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,   1, 5, 32'hDEADBEEF, 1, 32'h0,   0);
    tbl[2]  = mk(1, 0, 32'h1234,     0, 0, 0, 0, 0,   0, 0, 0,            1, 32'h0,   0);
    tbl[3]  = mk(0, 0, 0,            1, 7, 0, 0, 0,   0, 0, 0,            1, 32'h0,   0);
    tbl[4]  = mk(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0,            1, 32'h80,  0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 1, 7, 42,  0, 0, 0,            1, 32'h80,  0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0, 0, 0,   1, 7, 42,           1, 32'h80,  0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0,            1, 32'h0,   0);
    tbl[8]  = mk(1, 1, 11,           1, 8, 0, 0, 0,   1, 1, 11,           1, 32'h0,   0);
    tbl[9]  = mk(1, 1, 12,           1, 9, 0, 0, 0,   1, 1, 12,           1, 32'h100, 0);
    tbl[10] = mk(1, 2, 13,           0, 0, 1, 8, 80,  1, 2, 13,           1, 32'h300, 0);
    tbl[11] = mk(1, 2, 14,           0, 0, 1, 9, 90,  1, 2, 14,           1, 32'h300, 0);
    tbl[12] = mk(1, 2, 15,           0, 0, 0, 0, 0,   1, 2, 15,           0, 32'h300, 0);
    tbl[13] = mk(0, 0, 0,            0, 0, 0, 0, 0,   1, 8, 80,           0, 32'h300, 0);
    tbl[14] = mk(0, 0, 0,            0, 0, 0, 0, 0,   1, 9, 90,           1, 32'h200, 0);
    tbl[15] = mk(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0,            1, 32'h0,   0);
    tbl[16] = mk(0, 0, 0,            0, 0, 1, 0, 99,  0, 0, 0,            1, 32'h0,   0);
    tbl[17] = mk(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0,            1, 32'h0,   0);
    tbl[18] = mk(0, 0, 0,            1, 3, 0, 0, 0,   0, 0, 0,            1, 32'h0,   0);
    tbl[19] = mk(0, 0, 0,            0, 0, 1, 3, 33,  0, 0, 0,            1, 32'h8,   0);
    tbl[20] = mk(0, 0, 0,            1, 3, 0, 0, 0,   1, 3, 33,           1, 32'h8,   0);
    tbl[21] = mk(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0,            1, 32'h8,   1);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].pwe, tbl[i].pwa, tbl[i].pwd, tbl[i].iss, tbl[i].ird,
            tbl[i].mv, tbl[i].mrd, tbl[i].mwd);
      #3;
      chk($sformatf("tbl%0d_we3", i),   we3,       tbl[i].e_we);
      chk($sformatf("tbl%0d_wa3", i),   wa3,       tbl[i].e_wa);
      chk($sformatf("tbl%0d_wd3", i),   wd3,       tbl[i].e_wd);
      chk($sformatf("tbl%0d_rdy", i),   md_ready,  tbl[i].e_rdy);
      chk($sformatf("tbl%0d_busy", i),  busy_mask, tbl[i].e_busy);
      chk($sformatf("tbl%0d_err", i),   waw_err,   tbl[i].e_err);
      step();
    end

    // Asynchronous reset with a result queued behind a busy pipeline.
    drive(0, 0, 0, 1, 10, 0, 0, 0);
    step();
    drive(1, 20, 32'h55, 0, 0, 1, 10, 100);
    step();
    drive(1, 20, 32'h66, 0, 0, 0, 0, 0);
    #2;
    chk("async_pre_busy10", busy_mask[10], 1'b1);
    chk("async_pre_wa3", wa3, 5'd20);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy_mask, 32'h0);
    chk("async_err", waw_err, 1'b0);
    chk("async_rdy", md_ready, 1'b1);
    chk("async_we3", we3, 1'b0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    chk("post_reset_fifo_empty_we3", we3, 1'b0);
    step();

    // Pipeline write to a busy register: datapath proceeds, error latches and holds.
    drive(0, 0, 0, 1, 7, 0, 0, 0);
    step();
    drive(1, 7, 32'h5, 0, 0, 0, 0, 0);
    #3;
    chk("wawpipe_we3", we3, 1'b1);
    chk("wawpipe_wa3", wa3, 5'd7);
    chk("wawpipe_err_before", waw_err, 1'b0);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("wawpipe_err_hold%0d", k), waw_err, 1'b1);
      step();
    end

    // Randomized phase against the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) do_reset();
      idle();
      pipe_we = 1'($urandom_range(0, 1));
      pipe_wa = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
      pipe_wd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        r_pick = 5'($urandom_range(1, 15));
        if (!mbusy[r_pick] || $urandom_range(0, 29) == 0) begin
          md_issue = 1'b1;
          md_issue_rd = r_pick;
        end
      end
      from_pend = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        md_valid = 1'b1;
        md_rd = pend[0];
        md_wd = $urandom;
        from_pend = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        md_valid = 1'b1;
        md_rd = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
        md_wd = $urandom;
      end
      #3;
      slot  = pipe_we && (pipe_wa != 5'd0);
      x_rdy = (q.size() < DEPTH);
      x_we = 1'b0; x_wa = 5'd0; x_wd = 32'd0;
      if (slot) begin
        x_we = 1'b1; x_wa = pipe_wa; x_wd = pipe_wd;
      end else if (q.size() > 0) begin
        x_we = 1'b1; x_wa = q[0].rd; x_wd = q[0].wd;
      end
      for (int j = 0; j < 32; j++) x_busy[j] = mbusy[j];
      chk("rnd_we3", we3, x_we);
      chk("rnd_wa3", wa3, x_wa);
      chk("rnd_wd3", wd3, x_wd);
      chk("rnd_rdy", md_ready, x_rdy);
      chk("rnd_busy", busy_mask, x_busy);
      chk("rnd_err", waw_err, merr);
      acc   = md_valid && x_rdy;
      drain = !slot && (q.size() > 0);
      if (slot && mbusy[pipe_wa]) merr = 1'b1;
      if (md_issue && md_issue_rd != 5'd0 && mbusy[md_issue_rd]) merr = 1'b1;
      if (acc && md_rd != 5'd0 && !mbusy[md_rd]) merr = 1'b1;
      if (drain) begin
        hrd = q[0].rd;
        mbusy[hrd] = 1'b0;
        void'(q.pop_front());
      end
      if (md_issue && md_issue_rd != 5'd0) mbusy[md_issue_rd] = 1'b1;
      if (acc && md_rd != 5'd0) q.push_back('{rd: md_rd, wd: md_wd});
      if (acc && from_pend) void'(pend.pop_front());
      if (md_issue && md_issue_rd != 5'd0) pend.push_back(md_issue_rd);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Owns the register file's single write port (we3/wa3/wd3).
- Merges two producers onto that port: the in-order pipeline writeback, which always wins, and results from the iterative multiply/divide unit.
- Mul/div results are queued in a small FIFO and drained into idle write slots.
- Keeps a pending-destination scoreboard (busy_mask) that the hazard unit uses to stall readers and writers of in-flight mul/div destinations.

Parameters:
- N, 32, data width; matches regfile n.
- R, 5, register address width; matches regfile r.
- DEPTH, 2, mul/div result FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_we  in  1  pipeline writeback valid.
- pipe_wa  in  R  pipeline destination register.
- pipe_wd  in  N  pipeline writeback data.
- md_issue  in  1  mul/div op issued this cycle.
- md_issue_rd  in  R  destination of the issued mul/div op.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  result accepted when md_valid && md_ready.
- md_rd  in  R  result destination.
- md_wd  in  N  result data.
- we3  out  1  regfile write enable.
- wa3  out  R  regfile write address.
- wd3  out  N  regfile write data.
- busy_mask  out  2**R  bit i set means register i has an outstanding mul/div write.
- waw_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty, busy_mask = 0, waw_err = 0, md_ready = 1. During reset we3 = 0.
- State: FIFO of DEPTH entries {rd, wd}, busy_mask register, waw_err register.
- Write port (combinational from current inputs and FIFO head):
  - pipe_slot = pipe_we && pipe_wa != 0.
  - If pipe_slot: we3 = 1, wa3 = pipe_wa, wd3 = pipe_wd.
  - Else if the FIFO is non-empty: we3 = 1, wa3/wd3 = head rd/wd, and the head pops at the clock edge (the "drain" event).
  - Else: we3 = 0, wa3 = 0, wd3 = 0.
- Pipeline writes to r0 are dropped and do not consume the slot, so the FIFO may drain in that cycle.
- md_ready = !full, registered from FIFO occupancy only. There is no same-cycle pop-then-push look-through: a full FIFO stays not-ready for that cycle even if it drains.
- Accept (md_valid && md_ready):
  - md_rd != 0: push {md_rd, md_wd} at the tail.
  - md_rd == 0: handshake completes and the data is discarded.
- No bypass. Minimum latency is 1 cycle from accept to we3. Results write in acceptance order.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect, and occupancy is unchanged.
- busy_mask:
  - Set bit md_issue_rd on md_issue when md_issue_rd != 0.
  - Clear bit head.rd on drain.
  - Set and clear of the same bit in the same cycle: set wins.
- Starvation: continuous pipe_slot cycles hold off draining. The FIFO fills and md_ready deasserts. This is legal backpressure, and the mul/div unit holds its result.
- waw_err is set (and held until reset) on any of:
  - pipe_slot to a register whose busy bit is set;
  - md_issue to a nonzero register already busy;
  - an accepted md result with md_rd != 0 whose busy bit is clear.
- On any waw_err cause the normal datapath action still occurs.
- Reset mid-operation: queued results are lost and busy_mask clears. Upstream is reset in the same domain.

Decomposition:
- Shared package wb_pkg:
  - constants N_DEF = 32, R_DEF = 5;
  - typedef md_entry_t, a packed struct {logic [R-1:0] rd; logic [N-1:0] wd}.
- Sub-module sync_fifo: parameterised width/depth, push/pop/full/empty/head, same clk/rst_n.
- Arbitration, scoreboard and error logic stay in wb_arbiter.

Test Plan:
- Reset: after rst_n is released, we3 = 0, md_ready = 1, busy_mask = 0, waw_err = 0.
- Pipe only: pipe_we = 1, pipe_wa = 5, pipe_wd = 0xDEADBEEF -> same cycle we3 = 1, wa3 = 5, wd3 = 0xDEADBEEF. With pipe_wa = 0 -> we3 = 0.
- Mul/div path:
  - md_issue rd = 7 -> busy_mask[7] = 1 the next cycle.
  - Result rd = 7, wd = 42 accepted with the pipe idle -> next cycle we3 = 1, wa3 = 7, wd3 = 42.
  - The cycle after that, busy_mask[7] = 0.
- Contention/backpressure:
  - Hold pipe_slot every cycle, issue rd 8 and 9, then accept results for 8 and 9 -> md_ready = 0 after 2 accepts and the FIFO write is deferred.
  - Drop the pipe -> writes 8 then 9 on consecutive cycles, and md_ready returns to 1.
- Edge cases:
  - md_rd = 0 accepted -> no write and no FIFO occupancy.
  - md_issue rd = 3 in the same cycle that a queued rd = 3 drains -> busy_mask[3] stays 1.
- Errors:
  - Pipe write to busy rd 7 -> waw_err = 1 and stays 1.
  - Asserting rst_n = 0 mid-queue -> FIFO empty, busy_mask = 0, waw_err = 0 immediately (asynchronously).
